weight_loader: RTL and testbench

//   Streaming writer for the model's shared weight bus (weight_wr_data/addr/en).

---
 rtl/weight_loader_if.sv | 30 +++
 rtl/weight_loader.sv | 121 ++++++++++++
 tb/tb_weight_loader.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader_if
// Description : Host stream (valid/ready) plus weight-bus write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] weight_wr_data;
    logic [ADDR_WIDTH-1:0] weight_wr_addr;
    logic                  weight_wr_en;

    // Host side: drives the stream, observes the bus.
    modport master (
        output s_data, s_valid,
        input  s_ready, weight_wr_data, weight_wr_addr, weight_wr_en
    );

    // Loader side.
    modport slave (
        input  s_data, s_valid,
        output s_ready, weight_wr_data, weight_wr_addr, weight_wr_en
    );
endinterface
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_loader
// Description : Writes a streamed block of weight words to consecutive bus
//               addresses, with done pulse, word count and running checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_WORDS  = 135
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic                  abort,
    input  wire logic [CNT_WIDTH-1:0]  num_words,
    weight_loader_if.slave             bus,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       words_written,
    output logic [DATA_WIDTH-1:0]      checksum
);

    localparam logic [CNT_WIDTH-1:0] c_default_len = CNT_WIDTH'(NUM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_xfer;
    logic                    w_start_ok;
    logic [CNT_WIDTH-1:0]    w_words_inc;

    logic [CNT_WIDTH-1:0]    r_len;
    logic [ADDR_WIDTH-1:0]   r_next_addr;
    logic [CNT_WIDTH-1:0]    r_words;
    logic [DATA_WIDTH-1:0]   r_checksum;
    logic                    r_wr_en;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;

    assign w_words_inc = r_words + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort is checked before the last-word test so it always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_xfer = bus.s_valid;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer && (w_words_inc == r_len)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_next_addr <= '0;
            r_words     <= '0;
            r_checksum  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_start_ok) begin
                r_len       <= (num_words == '0) ? c_default_len : num_words;
                r_next_addr <= BASE_ADDR;
                r_words     <= '0;
                r_checksum  <= '0;
            end
            if (w_xfer) begin
                r_wr_data   <= bus.s_data;
                r_wr_addr   <= r_next_addr;
                r_next_addr <= r_next_addr + 1'b1;
                r_words     <= w_words_inc;
                r_checksum  <= r_checksum + bus.s_data;
            end
        end
    end

    assign bus.s_ready        = (r_state == S_LOAD);
    assign bus.weight_wr_en   = r_wr_en;
    assign bus.weight_wr_data = r_wr_data;
    assign bus.weight_wr_addr = r_wr_addr;
    assign busy               = (r_state == S_LOAD);
    assign done               = (r_state == S_DONE);
    assign words_written      = r_words;
    assign checksum           = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_loader
// Description : Self-checking bench for weight_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

    localparam int              DW   = 32;
    localparam int              AW   = 32;
    localparam int              CW   = 16;
    localparam int              NWD  = 135;
    localparam logic [AW-1:0]   BASE = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_written;
    logic [DW-1:0] checksum;

    weight_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    weight_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW),
        .BASE_ADDR  (BASE),
        .NUM_WORDS  (NWD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_words     (num_words),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_done = 0;

    // Reference model: expected visible outputs plus the load bookkeeping.
    bit            m_loading;
    logic [CW-1:0] m_len;
    logic [AW-1:0] m_addr;
    bit            e_en;
    bit            e_done;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_ww;
    logic [DW-1:0] e_sum;

    typedef struct {
        logic [CW-1:0]          nw;
        int                     n;
        logic [3:0][DW-1:0]     d;
        logic [CW-1:0]          exp_ww;
        logic [DW-1:0]          exp_sum;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_len     = '0;
        m_addr    = BASE;
        e_en      = 1'b0;
        e_done    = 1'b0;
        e_data    = '0;
        e_addr    = '0;
        e_ww      = '0;
        e_sum     = '0;
    endtask

    task automatic check_all();
        check("s_ready",        64'(bus.s_ready),      64'(m_loading));
        check("busy",           64'(busy),             64'(m_loading));
        check("done",           64'(done),             64'(e_done));
        check("weight_wr_en",   64'(bus.weight_wr_en), 64'(e_en));
        check("weight_wr_addr", 64'(bus.weight_wr_addr), 64'(e_addr));
        check("weight_wr_data", 64'(bus.weight_wr_data), 64'(e_data));
        check("words_written",  64'(words_written),    64'(e_ww));
        check("checksum",       64'(checksum),         64'(e_sum));
    endtask

    // Advance the model over one clock using the inputs now applied, then
    // compare the DUT just after the edge.
    task automatic tick();
        bit xfer;
        bit nxt_loading;
        bit nxt_done;
        xfer        = m_loading && (bus.s_valid === 1'b1);
        nxt_loading = m_loading;
        nxt_done    = 1'b0;
        if (xfer) begin
            e_data = bus.s_data;
            e_addr = m_addr;
            m_addr = m_addr + 1;
            e_ww   = e_ww + 1;
            e_sum  = e_sum + bus.s_data;
        end
        if (m_loading) begin
            if (abort) begin
                nxt_loading = 1'b0;
            end else if (xfer && e_ww == m_len) begin
                nxt_loading = 1'b0;
                nxt_done    = 1'b1;
            end
        end else if (!e_done && start && !abort) begin
            m_len       = (num_words == '0) ? CW'(NWD) : num_words;
            m_addr      = BASE;
            e_ww        = '0;
            e_sum       = '0;
            nxt_loading = 1'b1;
        end
        e_en      = xfer;
        m_loading = nxt_loading;
        e_done    = nxt_done;
        @(posedge clk);
        #1;
        check_all();
        if (bus.weight_wr_en === 1'b1) n_wr++;
        if (done === 1'b1) n_done++;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic begin_load(input logic [CW-1:0] nw);
        n_wr      = 0;
        n_done    = 0;
        num_words = nw;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        tick();
        bus.s_valid = 1'b0;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        model_reset();

        vecs[0].nw = 16'd4; vecs[0].n = 4;
        vecs[0].d  = {32'd4, 32'd3, 32'd2, 32'd1};
        vecs[0].exp_ww = 16'd4; vecs[0].exp_sum = 32'd10;
        vecs[1].nw = 16'd2; vecs[1].n = 2;
        vecs[1].d  = {32'd0, 32'd0, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[1].exp_ww = 16'd2; vecs[1].exp_sum = 32'h0000_0001;
        vecs[2].nw = 16'd1; vecs[2].n = 1;
        vecs[2].d  = {32'd0, 32'd0, 32'd0, 32'hDEAD_BEEF};
        vecs[2].exp_ww = 16'd1; vecs[2].exp_sum = 32'hDEAD_BEEF;
        vecs[3].nw = 16'd3; vecs[3].n = 3;
        vecs[3].d  = {32'd0, 32'd30, 32'd20, 32'd10};
        vecs[3].exp_ww = 16'd3; vecs[3].exp_sum = 32'd60;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        tick();

        // Table-driven back-to-back loads
        for (int v = 0; v < 4; v++) begin
            begin_load(vecs[v].nw);
            for (int i = 0; i < vecs[v].n; i++) push(vecs[v].d[i]);
            tick();
            tick();
            check("vec_words_written", 64'(words_written), 64'(vecs[v].exp_ww));
            check("vec_checksum",      64'(checksum),      64'(vecs[v].exp_sum));
            check("vec_writes",        64'(n_wr),          64'(vecs[v].n));
            check("vec_done_pulses",   64'(n_done),        64'd1);
        end

        // Default length: 135 words 0..134
        begin_load(16'd0);
        for (int i = 0; i < NWD; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(i);
            tick();
        end
        idle_inputs();
        tick();
        tick();
        check("full_words_written", 64'(words_written), 64'd135);
        check("full_checksum",      64'(checksum),      64'd9045);
        check("full_writes",        64'(n_wr),          64'd135);
        check("full_done_pulses",   64'(n_done),        64'd1);

        // Valid toggling with stray data on idle cycles, then valid after done
        begin_load(16'd4);
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = (i % 2 == 0);
            bus.s_data  = (i % 2 == 0) ? 32'hA000_0000 + 32'(i / 2) : 32'hBAD0_0000 + 32'(i);
            tick();
        end
        repeat (3) push(32'h5555_5555);
        check("toggle_writes",      64'(n_wr),          64'd4);
        check("toggle_done_pulses", 64'(n_done),        64'd1);
        check("toggle_words",       64'(words_written), 64'd4);

        // Abort with a word transferred in the abort cycle
        begin_load(16'd5);
        push(32'd11);
        abort       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd22;
        tick();
        idle_inputs();
        tick();
        tick();
        check("abort_writes",   64'(n_wr),          64'd2);
        check("abort_done",     64'(n_done),        64'd0);
        check("abort_words",    64'(words_written), 64'd2);
        check("abort_checksum", 64'(checksum),      64'd33);
        check("abort_busy",     64'(busy),          64'd0);

        // Restart after abort: counters cleared, address back at base
        begin_load(16'd2);
        check("restart_words",    64'(words_written), 64'd0);
        check("restart_checksum", 64'(checksum),      64'd0);
        push(32'd5);
        check("restart_addr", 64'(bus.weight_wr_addr), 64'(BASE));
        push(32'd6);
        tick();

        // Abort wins over the last word
        begin_load(16'd2);
        push(32'd1);
        abort = 1'b1;
        push(32'd2);
        abort = 1'b0;
        tick();
        check("abort_last_done",  64'(n_done),        64'd0);
        check("abort_last_words", 64'(words_written), 64'd2);

        // Start during LOAD with a different length is ignored
        begin_load(16'd3);
        push(32'd100);
        start     = 1'b1;
        num_words = 16'd9;
        push(32'd200);
        start = 1'b0;
        for (int i = 0; i < 6; i++) push(32'd300 + 32'(i));
        check("restart_ignored_writes", 64'(n_wr),          64'd3);
        check("restart_ignored_words",  64'(words_written), 64'd3);

        // Start with abort in IDLE is ignored
        start     = 1'b1;
        abort     = 1'b1;
        num_words = 16'd2;
        tick();
        idle_inputs();
        check("start_abort_idle_busy", 64'(busy), 64'd0);
        tick();

        // Asynchronous reset mid-load
        begin_load(16'd10);
        push(32'h1234);
        push(32'h5678);
        push(32'h9ABC);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Randomized loads against the model
        for (int it = 0; it < 30; it++) begin
            begin_load(16'($urandom_range(0, 12)));
            for (int c = 0; c < 300; c++) begin
                bus.s_valid = ($urandom_range(0, 3) != 0);
                bus.s_data  = $urandom;
                abort       = ($urandom_range(0, 29) == 0);
                start       = ($urandom_range(0, 9) == 0);
                num_words   = 16'($urandom_range(0, 20));
                tick();
                if (!m_loading && !e_done) break;
            end
            idle_inputs();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
